// File: rtl/axis_sample_packer.sv
// axis_sample_packer
//   Single-clock AXI-Stream width upsizer. Packs RATIO consecutive IN_WIDTH-bit
//   input words into one IN_WIDTH*RATIO-bit output word, lane 0 (first accepted
//   word) in the LSBs. A word carrying s_rx_tlast flushes a partial word early,
//   with m_tx_tkeep marking the populated lanes.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   s_rx_tdata     input word (one lane)
//   s_rx_tlast     last word of packet, forces a flush
//   s_rx_tvalid    input valid
//   s_rx_tready    input ready (never depends on s_rx_tvalid)
//   m_tx_tdata     packed output word
//   m_tx_tkeep     per-lane valid mask
//   m_tx_tlast     packet end
//   m_tx_tvalid    output valid
//   m_tx_tready    output ready
module axis_sample_packer #(
   parameter int unsigned IN_WIDTH = 12,
   parameter int unsigned RATIO    = 4,
   parameter bit          ZERO_PAD = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [IN_WIDTH-1:0]          s_rx_tdata,
   input  logic                         s_rx_tlast,
   input  logic                         s_rx_tvalid,
   output logic                         s_rx_tready,
   output logic [IN_WIDTH*RATIO-1:0]    m_tx_tdata,
   output logic [RATIO-1:0]             m_tx_tkeep,
   output logic                         m_tx_tlast,
   output logic                         m_tx_tvalid,
   input  logic                         m_tx_tready
);

   localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;
   localparam int unsigned CNT_W     = $clog2(RATIO);
   localparam int unsigned ACC_WIDTH = IN_WIDTH * (RATIO - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

   logic [CNT_W-1:0]     cnt;
   logic [ACC_WIDTH-1:0] acc;
   logic                 acc_in;
   logic                 complete;
   logic                 out_free;
   logic [OUT_WIDTH-1:0] pack_data;
   logic [RATIO-1:0]     pack_keep;

   assign complete    = (cnt == CNT_LAST) || s_rx_tlast;
   assign out_free    = !m_tx_tvalid || m_tx_tready;
   // Words that do not complete a beat only touch the accumulator, so they
   // are taken even while the output register is stalled.
   assign s_rx_tready = out_free || !complete;
   assign acc_in      = s_rx_tvalid && s_rx_tready;

   // Assemble the beat that a completing word would produce.
   always_comb begin
      pack_data = '0;
      pack_keep = '0;
      for (int i = 0; i < RATIO - 1; i++) begin
         if (CNT_W'(i) < cnt) begin
            pack_data[i*IN_WIDTH +: IN_WIDTH] = acc[i*IN_WIDTH +: IN_WIDTH];
            pack_keep[i]                      = 1'b1;
         end else if (CNT_W'(i) == cnt) begin
            pack_data[i*IN_WIDTH +: IN_WIDTH] = s_rx_tdata;
            pack_keep[i]                      = 1'b1;
         end else if (!ZERO_PAD) begin
            pack_data[i*IN_WIDTH +: IN_WIDTH] = acc[i*IN_WIDTH +: IN_WIDTH];
         end
      end
      // Top lane has no accumulator slot: it is only ever the completing word.
      if (cnt == CNT_LAST) begin
         pack_data[OUT_WIDTH-1 -: IN_WIDTH] = s_rx_tdata;
         pack_keep[RATIO-1]                 = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         acc         <= '0;
         m_tx_tdata  <= '0;
         m_tx_tkeep  <= '0;
         m_tx_tlast  <= 1'b0;
         m_tx_tvalid <= 1'b0;
      end else begin
         if (acc_in && !complete) begin
            acc[cnt*IN_WIDTH +: IN_WIDTH] <= s_rx_tdata;
            cnt                           <= cnt + 1'b1;
         end

         // acc_in && complete implies out_free, so a load never overwrites
         // an undelivered beat; it may coincide with a drain.
         if (acc_in && complete) begin
            m_tx_tdata  <= pack_data;
            m_tx_tkeep  <= pack_keep;
            m_tx_tlast  <= s_rx_tlast;
            m_tx_tvalid <= 1'b1;
            cnt         <= '0;
         end else if (m_tx_tready) begin
            m_tx_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axis_sample_packer.sv
module tb_axis_sample_packer;

   localparam int unsigned IN_WIDTH  = 12;
   localparam int unsigned RATIO     = 4;
   localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;

   typedef struct {
      logic [OUT_WIDTH-1:0] d;
      logic [RATIO-1:0]     k;
      logic                 l;
   } beat_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [IN_WIDTH-1:0]  s_rx_tdata = '0;
   logic                 s_rx_tlast = 1'b0;
   logic                 s_rx_tvalid = 1'b0;
   logic                 s_rx_tready;
   logic [OUT_WIDTH-1:0] m_tx_tdata;
   logic [RATIO-1:0]     m_tx_tkeep;
   logic                 m_tx_tlast;
   logic                 m_tx_tvalid;
   logic                 m_tx_tready = 1'b1;

   int total = 0;
   int bad = 0;
   int stall_cnt = 0;

   logic [IN_WIDTH-1:0] part[$];
   beat_t exp_q[$];
   beat_t log_q[$];

   logic                 prev_stall = 1'b0;
   logic [OUT_WIDTH-1:0] prev_d;
   logic [RATIO-1:0]     prev_k;
   logic                 prev_l;

   axis_sample_packer #(
      .IN_WIDTH (IN_WIDTH),
      .RATIO    (RATIO),
      .ZERO_PAD (1'b1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_rx_tdata  (s_rx_tdata),
      .s_rx_tlast  (s_rx_tlast),
      .s_rx_tvalid (s_rx_tvalid),
      .s_rx_tready (s_rx_tready),
      .m_tx_tdata  (m_tx_tdata),
      .m_tx_tkeep  (m_tx_tkeep),
      .m_tx_tlast  (m_tx_tlast),
      .m_tx_tvalid (m_tx_tvalid),
      .m_tx_tready (m_tx_tready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: collect accepted words of the current packet; a beat is due
   // once RATIO words are held or a tlast word arrives.
   task automatic model_accept(input logic [IN_WIDTH-1:0] w, input logic l);
      beat_t b;
      part.push_back(w);
      if (part.size() == RATIO || l) begin
         b.d = '0;
         for (int i = 0; i < part.size(); i++) b.d[i*IN_WIDTH +: IN_WIDTH] = part[i];
         b.k = RATIO'((1 << part.size()) - 1);
         b.l = l;
         exp_q.push_back(b);
         part.delete();
      end
   endtask

   // Sampled on the falling edge: values here are what the next rising edge sees.
   always @(negedge clk) begin
      if (!rst_n) begin
         part.delete();
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         logic exp_ready;
         beat_t e;
         exp_ready = !(((part.size() == RATIO - 1) || s_rx_tlast) &&
                       (exp_q.size() != 0) && !m_tx_tready);
         check("rx_ready", 64'(s_rx_tready), 64'(exp_ready));
         check("tx_valid", 64'(m_tx_tvalid), 64'(exp_q.size() != 0));
         if (prev_stall) begin
            check("hold_data", 64'(m_tx_tdata), 64'(prev_d));
            check("hold_keep", 64'(m_tx_tkeep), 64'(prev_k));
            check("hold_last", 64'(m_tx_tlast), 64'(prev_l));
         end
         if (m_tx_tvalid && m_tx_tready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat_data", 64'(m_tx_tdata), 64'(e.d));
            check("beat_keep", 64'(m_tx_tkeep), 64'(e.k));
            check("beat_last", 64'(m_tx_tlast), 64'(e.l));
            e.d = m_tx_tdata;
            e.k = m_tx_tkeep;
            e.l = m_tx_tlast;
            log_q.push_back(e);
         end
         prev_stall = m_tx_tvalid && !m_tx_tready;
         prev_d     = m_tx_tdata;
         prev_k     = m_tx_tkeep;
         prev_l     = m_tx_tlast;
         if (s_rx_tvalid && !s_rx_tready) stall_cnt++;
         if (s_rx_tvalid && s_rx_tready) model_accept(s_rx_tdata, s_rx_tlast);
      end
   end

   // Returns one cycle after acceptance (rising edge + 1).
   task automatic send(input logic [IN_WIDTH-1:0] d, input logic l);
      int n = 0;
      s_rx_tdata  = d;
      s_rx_tlast  = l;
      s_rx_tvalid = 1'b1;
      @(negedge clk);
      while (!s_rx_tready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("send_timeout", 64'(n), 64'(0));
      @(posedge clk);
      #1;
      s_rx_tvalid = 1'b0;
      s_rx_tlast  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || m_tx_tvalid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic check_beat(input string name, input int idx, input logic [OUT_WIDTH-1:0] d,
                             input logic [RATIO-1:0] k, input logic l);
      if (idx < log_q.size()) begin
         check({name, "_data"}, 64'(log_q[idx].d), 64'(d));
         check({name, "_keep"}, 64'(log_q[idx].k), 64'(k));
         check({name, "_last"}, 64'(log_q[idx].l), 64'(l));
      end else begin
         check({name, "_missing"}, 64'(log_q.size()), 64'(idx + 1));
      end
   endtask

   initial begin
      int b0;
      int left;
      logic done;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_valid", 64'(m_tx_tvalid), 64'(0));
      check("rst_data", 64'(m_tx_tdata), 64'(0));
      check("rst_keep", 64'(m_tx_tkeep), 64'(0));
      check("rst_last", 64'(m_tx_tlast), 64'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: full beats, sink always ready
      b0 = log_q.size();
      stall_cnt = 0;
      for (int i = 1; i <= 8; i++) send(IN_WIDTH'(i), 1'b0);
      drain();
      check_beat("t1_b0", b0, 48'h004003002001, 4'hF, 1'b0);
      check_beat("t1_b1", b0 + 1, 48'h008007006005, 4'hF, 1'b0);
      check("t1_no_stall", 64'(stall_cnt), 64'(0));

      // 2: early flush after two words
      b0 = log_q.size();
      send(12'hA01, 1'b0);
      send(12'hA02, 1'b1);
      drain();
      check_beat("t2", b0, 48'h000000A02A01, 4'h3, 1'b1);

      // 3: single-word packet, visible the cycle after acceptance
      b0 = log_q.size();
      send(12'h5A5, 1'b1);
      check("t3_lat_valid", 64'(m_tx_tvalid), 64'(1));
      check("t3_lat_data", 64'(m_tx_tdata), 64'h0000000005A5);
      check("t3_lat_keep", 64'(m_tx_tkeep), 64'h1);
      drain();
      check_beat("t3", b0, 48'h0000000005A5, 4'h1, 1'b1);

      // 4: output stalled for 10 cycles under continuous input
      b0 = log_q.size();
      m_tx_tready = 1'b0;
      fork
         for (int i = 0; i < 8; i++) send(IN_WIDTH'(12'h100 + i), 1'b0);
         begin
            repeat (10) @(negedge clk);
            check("t4_stall_ready", 64'(s_rx_tready), 64'(0));
            check("t4_stall_valid", 64'(m_tx_tvalid), 64'(1));
            check("t4_stall_data", 64'(m_tx_tdata), 64'h103102101100);
            @(posedge clk);
            #1;
            m_tx_tready = 1'b1;
         end
      join
      drain();
      check_beat("t4_b0", b0, 48'h103102101100, 4'hF, 1'b0);
      check_beat("t4_b1", b0 + 1, 48'h107106105104, 4'hF, 1'b0);

      // 5: random valid/ready, random packet lengths
      done = 1'b0;
      left = $urandom_range(1, 9);
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               left--;
               repeat ($urandom_range(0, 1)) @(posedge clk);
               #1;
               send(IN_WIDTH'($urandom), (left == 0) || (i == 999));
               if (left == 0) left = $urandom_range(1, 9);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               m_tx_tready = 1'($urandom_range(0, 1));
            end
            m_tx_tready = 1'b1;
         end
      join
      drain();

      // 6: asynchronous reset mid-packet with a pending output beat
      m_tx_tready = 1'b0;
      send(12'h0C1, 1'b1);
      send(12'h0AA, 1'b0);
      send(12'h0BB, 1'b0);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 64'(m_tx_tvalid), 64'(0));
      check("t6_rst_keep", 64'(m_tx_tkeep), 64'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      m_tx_tready = 1'b1;
      @(posedge clk);
      #1;
      b0 = log_q.size();
      for (int i = 0; i < 4; i++) send(IN_WIDTH'(12'h011 + i), 1'b0);
      drain();
      check_beat("t6", b0, 48'h014013012011, 4'hF, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1);
   end

endmodule
